// File: rtl/k2_loader_pkg.sv
// Shared types and constants for the K2 program loader.
// Defines the loader FSM state encoding, the core address width and the instruction width.
package k2_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } loader_state_t;

    localparam int CORE_AW = 4;
    localparam int INSTR_W = 8;

endpackage

// File: rtl/K2_processor.sv
// K2 core: 4-bit program counter plus an accumulator exposed as Ro; one instruction per clock.
// Latency: Ro and ProgramAddress update on the edge that ends the instruction cycle.
// No backpressure; the synchronous active-low rst_n clears PC and Ro.
module K2_processor #(
    parameter int bits = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      Instruction,
    output logic [3:0]      ProgramAddress,
    output logic [bits-1:0] Ro
);

    logic [3:0]      pc;
    logic [bits-1:0] acc;
    logic [bits-1:0] imm;

    // opcode[7:6]: 00 add imm6, 01 xor imm6, 10 load imm6, 11 jump to [3:0]
    assign imm = bits'(Instruction[5:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc  <= '0;
            acc <= '0;
        end else begin
            unique case (Instruction[7:6])
                2'b00: begin acc <= acc + imm; pc <= pc + 4'd1; end
                2'b01: begin acc <= acc ^ imm; pc <= pc + 4'd1; end
                2'b10: begin acc <= imm;       pc <= pc + 4'd1; end
                default: pc <= Instruction[3:0];
            endcase
        end
    end

    assign ProgramAddress = pc;
    assign Ro             = acc;

endmodule

// File: rtl/k2_prog_ram.sv
// Paged instruction RAM: synchronous write, asynchronous read; K2_LOADER_READBACK_EN adds a debug read port.
// Latency: a write lands at the clock edge, reads are combinational.
// No backpressure; the write is accepted whenever we is high.
module k2_prog_ram
    import k2_loader_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
`ifdef K2_LOADER_READBACK_EN
    ,
    input  logic [ADDR_W-1:0]  dbg_addr,
    output logic [INSTR_W-1:0] dbg_data
`endif
);

    logic [INSTR_W-1:0] mem [1<<ADDR_W];

    // Contents deliberately survive reset so a program outlives a core restart.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

`ifdef K2_LOADER_READBACK_EN
    assign dbg_data = mem[dbg_addr];
`endif

endmodule

// File: rtl/k2_program_loader_exec.sv
// K2 execution harness: byte-stream loads a paged instruction RAM, then runs the core for N cycles (K2_LOADER_READBACK_EN adds RAM readback).
// Latency: done rises N+1 cycles after run_start; Ro lags the core by one cycle.
// Backpressure: load_ready is high only in LOAD; starts are ignored while busy.
module k2_program_loader_exec
    import k2_loader_pkg::*;
#(
    parameter int bits   = 8,
    parameter int ADDR_W = 6,
    parameter int CYC_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    input  logic               run_start,
    input  logic [ADDR_W-5:0]  run_page,
    input  logic [CYC_W-1:0]   run_cycles,
    output logic               busy,
    output logic               done,
    output logic [bits-1:0]    Ro
`ifdef K2_LOADER_READBACK_EN
    ,
    input  logic [ADDR_W-1:0]  dbg_addr,
    output logic [INSTR_W-1:0] dbg_data
`endif
);

    localparam int PG_W = ADDR_W - 4;

    loader_state_t      state;
    logic [ADDR_W-1:0]  ptr;
    logic [PG_W-1:0]    page_q;
    logic [CYC_W-1:0]   cnt;
    logic [bits-1:0]    ro_q;
    logic [bits-1:0]    core_ro;
    logic [CORE_AW-1:0] core_pa;
    logic [ADDR_W-1:0]  instr_addr;
    logic [INSTR_W-1:0] instr;
    logic               core_rst_n;
    logic               ram_we;

    assign load_ready = (state == LOAD);
    assign busy       = (state == LOAD) || (state == RUN);
    assign done       = (state == DONE);
    assign core_rst_n = (state == RUN);
    assign ram_we     = load_ready & load_valid;
    assign instr_addr = {page_q, core_pa};
    assign Ro         = ro_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            page_q <= '0;
            cnt    <= '0;
            ro_q   <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    // A simultaneous run request loses to the load.
                    if (load_start) begin
                        state <= LOAD;
                        ptr   <= '0;
                    end else if (run_start) begin
                        page_q <= run_page;
                        cnt    <= run_cycles;
                        state  <= (run_cycles == '0) ? DONE : RUN;
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        ptr <= ptr + 1'b1;
                        if (load_last || (&ptr)) begin
                            state <= IDLE;
                        end
                    end
                end
                RUN: begin
                    ro_q <= core_ro;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CYC_W'(1)) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    k2_prog_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk      (clk),
        .we       (ram_we),
        .waddr    (ptr),
        .wdata    (load_data),
        .raddr    (instr_addr),
        .rdata    (instr)
`ifdef K2_LOADER_READBACK_EN
        ,
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`endif
    );

    K2_processor #(
        .bits (bits)
    ) u_core (
        .clk            (clk),
        .rst_n          (core_rst_n),
        .Instruction    (instr),
        .ProgramAddress (core_pa),
        .Ro             (core_ro)
    );

endmodule

// File: tb/tb_k2_program_loader_exec.sv
// Randomized self-checking bench for k2_program_loader_exec against a behavioural memory/core model.
module tb_k2_program_loader_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start, load_valid, load_last, load_ready;
    logic [7:0]  load_data;
    logic        run_start;
    logic [1:0]  run_page;
    logic [15:0] run_cycles;
    logic        busy, done;
    logic [7:0]  Ro;
`ifdef K2_LOADER_READBACK_EN
    logic [5:0]  dbg_addr = '0;
    logic [7:0]  dbg_data;
`endif

    always #5 clk = ~clk;

    k2_program_loader_exec #(.bits(8), .ADDR_W(6), .CYC_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .run_start  (run_start),
        .run_page   (run_page),
        .run_cycles (run_cycles),
        .busy       (busy),
        .done       (done),
        .Ro         (Ro)
`ifdef K2_LOADER_READBACK_EN
        ,
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
`endif
    );

    int         n_chk = 0;
    int         n_fail = 0;
    int         wr_cnt = 0;
    logic [7:0] model_mem [64];
    logic [7:0] ld_buf [64];
    logic [7:0] ro_model = 8'h00;

    always @(posedge clk) if (dut.ram_we === 1'b1) wr_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Core value visible during the n-th out-of-reset cycle, i.e. after n-1 instructions.
    function automatic logic [7:0] model_core(input int page, input int n);
        int         pc = 0;
        logic [7:0] r = 8'h00;
        logic [7:0] seen = 8'h00;
        logic [7:0] ins;
        for (int i = 0; i < n; i++) begin
            seen = r;
            ins  = model_mem[page*16 + pc];
            case (ins[7:6])
                2'b00: r = r + {2'b00, ins[5:0]};
                2'b01: r = r ^ {2'b00, ins[5:0]};
                2'b10: r = {2'b00, ins[5:0]};
                default: ;
            endcase
            pc = (ins[7:6] == 2'b11) ? int'(ins[3:0]) : (pc + 1) % 16;
        end
        return seen;
    endfunction

    task automatic check_mem(input string tag, input int words);
        for (int i = 0; i < words; i++) chk(tag, dut.u_ram.mem[i], model_mem[i]);
    endtask

    task automatic do_load(input int n, input bit use_last, input bit toggle, input bit with_run);
        int sent = 0;
        int cyc  = 0;
        bit hs;
        load_start = 1'b1;
        run_start  = with_run;
        run_page   = 2'd1;
        run_cycles = 16'd5;
        step();
        load_start = 1'b0;
        run_start  = 1'b0;
        chk("load_ready_rise", load_ready, 1);
        if (with_run) chk("core_held_in_load", dut.core_rst_n, 0);
        wr_cnt = 0;
        while (sent < n && cyc < 400) begin
            load_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            load_data  = ld_buf[sent];
            load_last  = use_last && (sent == n - 1);
            hs = load_valid && load_ready;
            step();
            if (hs) begin
                model_mem[sent] = ld_buf[sent];
                sent++;
            end
            cyc++;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("load_bytes_accepted", sent, n);
        chk("load_ready_drop", load_ready, 0);
        chk("load_write_count", wr_cnt, n);
        chk("busy_after_load", busy, 0);
    endtask

    task automatic do_run(input int page, input int n);
        logic [7:0] exp;
        int runc = 0;
        int k = 1;
        bit addr_ok = 1'b1;
        exp = (n == 0) ? ro_model : model_core(page, n);
        run_page   = 2'(page);
        run_cycles = 16'(n);
        run_start  = 1'b1;
        step();
        run_start = 1'b0;
        while (!done && k <= n + 4) begin
            if (dut.core_rst_n === 1'b1) begin
                runc++;
                if (int'(dut.instr_addr[5:4]) != page) addr_ok = 1'b0;
            end
            step();
            k++;
        end
        chk("run_core_cycles", runc, n);
        chk("done_latency", k, n + 1);
        chk("done_high", done, 1);
        chk("fetch_in_page", addr_ok, 1);
        chk("ro_final", Ro, exp);
        step();
        chk("ro_frozen", Ro, exp);
        ro_model = exp;
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        load_data = 8'h00; run_start = 1'b0; run_page = 2'd0; run_cycles = 16'd0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_load_ready", load_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ro", Ro, 0);

        for (int i = 0; i < 16; i++) ld_buf[i] = 8'(8'h10 + i);
        do_load(16, 1'b1, 1'b0, 1'b0);
        check_mem("mem_seq", 16);
        do_load(16, 1'b1, 1'b1, 1'b0);
        check_mem("mem_toggle", 16);

        for (int i = 0; i < 64; i++) ld_buf[i] = 8'($urandom);
        do_load(64, 1'b0, 1'b0, 1'b0);
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        chk("full_load_no_extra_write", wr_cnt, 64);
        check_mem("mem_full", 64);

        do_run(2, 5);

        ld_buf[0] = 8'($urandom);
        do_load(1, 1'b1, 1'b0, 1'b1);
        chk("no_run_after_load_win", done, 0);
        do_run(3, 0);

        for (int it = 0; it < 8; it++) begin
            int len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) ld_buf[i] = 8'($urandom);
            do_load(len, 1'b1, 1'($urandom % 2), 1'b0);
            do_run($urandom_range(0, 3), $urandom_range(0, 30));
        end
        check_mem("mem_random", 64);

        run_page = 2'd3; run_cycles = 16'd10; run_start = 1'b1;
        step();
        run_start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ro_model = 8'h00;
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_done", done, 0);
        chk("midrun_rst_ro", Ro, 0);
        chk("midrun_rst_core", dut.core_rst_n, 0);
        check_mem("mem_after_rst", 64);
        do_run(1, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/k2_program_loader_exec.md
# k2_program_loader_exec

Parametrised program-execution harness for the K2 core. It replaces a fixed combinational program ROM with a writable, paged instruction RAM, filled over a byte-stream valid/ready port. A loader/run FSM holds the K2 core in reset while idle or loading, then releases it for a programmed number of cycles. The last core output is retained after the run ends. The block sits at the top of an execution testbed, between a host/loader and one `K2_processor` instance.

## Interface
Parameters:
- `bits`, 8: K2 data width, passed to the core; width of `Ro`.
- `ADDR_W`, 6: instruction RAM address width (≥5). Depth is 2**ADDR_W. Page width `PG_W` = ADDR_W-4.
- `CYC_W`, 16: width of the run-cycle budget.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `load_start`  in  1: begin a program load (accepted in IDLE/DONE).
- `load_valid`  in  1: byte-stream valid.
- `load_data`  in  8: instruction byte.
- `load_last`  in  1: marks the final byte of the load.
- `load_ready`  out  1: high only in LOAD.
- `run_start`  in  1: begin a run (accepted in IDLE/DONE).
- `run_page`  in  PG_W: program page, sampled on `run_start`.
- `run_cycles`  in  CYC_W: core cycle budget N, sampled on `run_start`.
- `busy`  out  1: state is LOAD or RUN.
- `done`  out  1: state is DONE (sticky until the next accepted start).
- `Ro`  out  bits: registered copy of the core's `Ro`.

## Operation
- States: IDLE, LOAD, RUN, DONE. Reset → IDLE.
- IDLE/DONE + `load_start` → LOAD; write pointer cleared to 0. If `load_start` and `run_start` are asserted in the same cycle, load wins and the run request is dropped.
- IDLE/DONE + `run_start` (no `load_start`) → RUN. The block latches `page_q`=`run_page`, `cnt`=`run_cycles`. If `run_cycles`=0, it goes → DONE instead, with zero core cycles.
- LOAD: a byte is accepted on `load_valid & load_ready`. The accepted byte writes `mem[ptr]`, then `ptr`++. The load exits → IDLE after an accepted byte with `load_last`, or after the byte written at `ptr`=DEPTH-1, whichever comes first. Unwritten words keep their prior contents. `load_start`/`run_start` are ignored in LOAD.
- RUN: the core's active-low reset input is driven high only in RUN; in every other state it is held low. Instruction address = {`page_q`, core `ProgramAddress`[3:0]}, read combinationally. `Ro` register captures core `Ro` every RUN cycle. `cnt` decrements each RUN cycle; the cycle in which `cnt`=1 is the last RUN cycle, and the next state is DONE. Starts are ignored in RUN.
- DONE: the core is back in reset and `Ro` holds its last RUN-cycle value. DONE accepts starts exactly as IDLE does.
- Page wrap: the core address wraps within its 16-word page; pages never cross.

## Timing
- Reset values: state IDLE, `load_ready`=0, `busy`=0, `done`=0, `Ro`=0, `ptr`=0, `page_q`=0, `cnt`=0. RAM contents are not reset.
- `load_ready` rises the cycle after `load_start` is accepted.
- A RAM write takes effect at the accepting edge and is readable combinationally from the next cycle.
- A run with budget N gives exactly N core-out-of-reset cycles. `done` rises N+1 cycles after the `run_start` edge; with N=0 it rises one cycle after.
- `Ro` lags core `Ro` by one cycle and freezes from the first DONE cycle.
- Reset mid-LOAD or mid-RUN → IDLE next edge. Bytes already written are kept, and `Ro` is cleared.

## Configuration
- `K2_LOADER_READBACK_EN` defined: adds `dbg_addr` (in, ADDR_W) and `dbg_data` (out, 8), a combinational second read port on the RAM, usable in any state.
- Undefined: these ports and the second read port are absent; behaviour is otherwise identical.

## Structure
- Package `k2_loader_pkg`:
  - `loader_state_t` enum (IDLE, LOAD, RUN, DONE);
  - `CORE_AW`=4 constant;
  - `INSTR_W`=8 constant.
- Sub-module `k2_prog_ram`: DEPTH×8 array with synchronous write and asynchronous read, plus the optional readback port.
- FSM, pointer, counter and `Ro` register live in the top. `K2_processor` is instantiated directly.

## Test plan
- Reset, then load 16 bytes 0x10..0x1F on page 0 with `load_last` on the 16th. Required: `load_ready` drops the next cycle, and readback shows mem[0..15]=0x10..0x1F.
- Repeat the load with `load_valid` toggled every other cycle. Required: exactly 16 writes, no duplicates, same contents.
- Load 64 bytes with no `load_last`. Required: exit → IDLE after address 63, and `load_ready` is 0 afterwards.
- `run_start` with `run_page`=2 and `run_cycles`=5. Required: core out of reset for exactly 5 cycles, fetch addresses 32..47 only, `done` on cycle 6, and `Ro` equal to the golden-model core value after cycle 5.
- `load_start` and `run_start` asserted together in IDLE. Required: LOAD entered and no run occurs. `run_cycles`=0 gives `done` after 1 cycle with `Ro` unchanged.
- `rst` asserted in the 3rd RUN cycle. Required: IDLE, `Ro`=0, `done`=0, and the previously loaded RAM contents still read back intact.
